// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline control block living in ID next to the decoder. It drives the
// write-enable and synchronous-flush pins of the PC, IF/ID, ID/EX and EX/MEM
// stage-register banks. It covers three cases:
//   - load-use hazards: hold PC and IF/ID and insert one bubble into ID/EX
//   - taken branches:   kill the two younger instructions (IF/ID, ID/EX)
//   - multi-cycle EX ops: hold the op in EX for MUL_CYCLES cycles in total,
//     while bubbles are fed into EX/MEM
//
// Ports
//   Clk, Reset         clock (rising edge); asynchronous active-low reset
//   ID_Rs, ID_Rt       source registers of the instruction in ID
//   ID_UsesRt          ID instruction actually reads Rt
//   ID_MultiCycle      ID instruction is a multi-cycle EX op
//   EX_MemRead, EX_Rd  EX instruction is a load, and its destination register
//   EX_BranchTaken     branch in EX resolved taken this cycle
//   PC_Write, IFID_Write, IDEX_Write       stage write enables
//   IFID_Flush, IDEX_Flush, EXMEM_Flush    stage synchronous clears
//   Busy               a multi-cycle op is being held in EX
//   StallCount         MC_BUSY cycles still remaining (0 in RUN)
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic                  ID_MultiCycle,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_Rd,
  input  logic                  EX_BranchTaken,
  output logic                  PC_Write,
  output logic                  IFID_Write,
  output logic                  IDEX_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Flush,
  output logic                  EXMEM_Flush,
  output logic                  Busy,
  output logic [CNT_W-1:0]      StallCount
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  // With a single-cycle "multi-cycle" op there is nothing to hold, so the
  // flag is ignored entirely.
  localparam bit              MC_ENABLE = (MUL_CYCLES >= 2);
  localparam logic [CNT_W-1:0] MC_LOAD  = CNT_W'(MUL_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             load_use;

  // Register 0 is hard-wired zero, so a load targeting it never creates a
  // real dependence. Rt only matters when the ID instruction reads it.
  assign load_use = EX_MemRead && (EX_Rd != '0) &&
                    ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= RUN;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state and counter.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      RUN: begin
        count_next = '0;
        // Branch and load-use both outrank the multi-cycle issue: the op in
        // ID is either killed or held back, so it must not start.
        if (MC_ENABLE && ID_MultiCycle && !EX_BranchTaken && !load_use) begin
          state_next = MC_BUSY;
          count_next = MC_LOAD;
        end
      end
      MC_BUSY: begin
        // Count <= 1 rather than == 1 so a corrupted zero count cannot wedge
        // the FSM in MC_BUSY.
        if (count_reg <= CNT_W'(1)) begin
          state_next = RUN;
          count_next = '0;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = RUN;
        count_next = '0;
      end
    endcase
  end

  // Outputs: combinational from state, count and inputs, so hazard response
  // lands in the same cycle the hazard is presented.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    Busy        = 1'b0;
    StallCount  = '0;

    if (!Reset) begin
      // Hold every stage and clear it while reset is low, regardless of
      // what the state register contains.
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
    end else if (state_reg == MC_BUSY) begin
      // The op stays in EX and everything upstream freezes. Bubbles go into
      // EX/MEM until the result is ready. Hazard inputs are ignored here.
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Flush = 1'b1;
      Busy        = 1'b1;
      StallCount  = count_reg;
    end else if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (load_use) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Self-checking bench for hazard_stall_unit (default parameters). Inputs are
// driven on the falling clock edge and outputs are sampled 1 time unit
// later, well away from the rising edge that updates the state register.
// Observed outputs are packed as
//   {PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
//    Busy, StallCount[3:0]}
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam int REG_ADDR_W = 5;
  localparam int MUL_CYCLES = 4;
  localparam int CNT_W      = 4;

  logic                  Clk;
  logic                  Reset;
  logic [REG_ADDR_W-1:0] ID_Rs;
  logic [REG_ADDR_W-1:0] ID_Rt;
  logic                  ID_UsesRt;
  logic                  ID_MultiCycle;
  logic                  EX_MemRead;
  logic [REG_ADDR_W-1:0] EX_Rd;
  logic                  EX_BranchTaken;
  logic                  PC_Write;
  logic                  IFID_Write;
  logic                  IDEX_Write;
  logic                  IFID_Flush;
  logic                  IDEX_Flush;
  logic                  EXMEM_Flush;
  logic                  Busy;
  logic [CNT_W-1:0]      StallCount;

  hazard_stall_unit #(
    .REG_ADDR_W(REG_ADDR_W),
    .MUL_CYCLES(MUL_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .ID_UsesRt     (ID_UsesRt),
    .ID_MultiCycle (ID_MultiCycle),
    .EX_MemRead    (EX_MemRead),
    .EX_Rd         (EX_Rd),
    .EX_BranchTaken(EX_BranchTaken),
    .PC_Write      (PC_Write),
    .IFID_Write    (IFID_Write),
    .IDEX_Write    (IDEX_Write),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Flush    (IDEX_Flush),
    .EXMEM_Flush   (EXMEM_Flush),
    .Busy          (Busy),
    .StallCount    (StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected-output constants.
  localparam logic [10:0] O_RUN    = 11'b111_000_0_0000;
  localparam logic [10:0] O_LDUSE  = 11'b001_010_0_0000;
  localparam logic [10:0] O_BRANCH = 11'b111_110_0_0000;
  localparam logic [10:0] O_RESET  = 11'b000_111_0_0000;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic        mc;
    logic        mem_read;
    logic [4:0]  rd;
    logic        br;
    logic [10:0] exp;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  int n_vec;
  int n_bad;

  function automatic logic [10:0] observed();
    return {PC_Write, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Flush,
            EXMEM_Flush, Busy, StallCount};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = observed();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic mc,
                       input logic mem_read, input logic [4:0] rd,
                       input logic br);
    ID_Rs          = rs;
    ID_Rt          = rt;
    ID_UsesRt      = uses_rt;
    ID_MultiCycle  = mc;
    EX_MemRead     = mem_read;
    EX_Rd          = rd;
    EX_BranchTaken = br;
  endtask

  task automatic drive_idle();
    drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses_rt, input logic mc,
                              input logic mem_read, input logic [4:0] rd,
                              input logic br, input logic [10:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.mc = mc;
    v.mem_read = mem_read; v.rd = rd; v.br = br; v.exp = exp;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;

    // RUN-state vectors; each is one cycle and none starts a multi-cycle op,
    // so every row also confirms the previous one left the FSM in RUN.
    //              rs     rt     ut    mc    mr    rd     br    expected
    vecs[0]  = mk(5'd1,  5'd2,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, O_RUN);
    vecs[1]  = mk(5'd5,  5'd2,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, O_LDUSE);  // Rs match
    vecs[2]  = mk(5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, O_RUN);    // rd==0
    vecs[3]  = mk(5'd3,  5'd5,  1'b0, 1'b0, 1'b1, 5'd5,  1'b0, O_RUN);    // Rt unused
    vecs[4]  = mk(5'd3,  5'd5,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, O_LDUSE);  // Rt match
    vecs[5]  = mk(5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 5'd5,  1'b0, O_RUN);    // not a load
    vecs[6]  = mk(5'd1,  5'd2,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, O_BRANCH);
    vecs[7]  = mk(5'd5,  5'd5,  1'b1, 1'b1, 1'b1, 5'd5,  1'b1, O_BRANCH); // br > ldu > mc
    vecs[8]  = mk(5'd1,  5'd2,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, O_RUN);    // Busy stayed 0
    vecs[9]  = mk(5'd31, 5'd4,  1'b0, 1'b1, 1'b1, 5'd31, 1'b0, O_LDUSE);  // ldu > mc
    vecs[10] = mk(5'd1,  5'd2,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, O_RUN);    // no MC entry

    // ---------------- reset held low, random inputs ----------------
    Reset = 1'b0;
    drive_idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 5'($urandom), 1'($urandom));
      #1;
      check($sformatf("reset_hold%0d", c), O_RESET);
    end
    @(negedge Clk);
    drive_idle();
    Reset = 1'b1;
    #1;
    check("reset_release", O_RUN);

    // ---------------- table-driven RUN vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge Clk);
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mc,
            vecs[i].mem_read, vecs[i].rd, vecs[i].br);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---------------- multi-cycle op, hazards ignored while busy ----------
    @(negedge Clk);
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    check("mc_issue", O_RUN);
    for (int k = 3; k >= 1; k--) begin
      @(negedge Clk);
      if (k == 2)
        drive(5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1);  // branch + load-use
      else
        drive_idle();
      #1;
      check($sformatf("mc_busy_cnt%0d", k), {7'b000_001_1, 4'(k)});
    end
    @(negedge Clk);
    drive_idle();
    #1;
    check("mc_done", O_RUN);

    // ---------------- asynchronous reset mid-op ----------------
    @(negedge Clk);
    drive(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge Clk);
    drive_idle();
    #1;
    check("ar_busy_cnt3", 11'b000_001_1_0011);
    @(negedge Clk);
    #1;
    check("ar_busy_cnt2", 11'b000_001_1_0010);
    #2;
    Reset = 1'b0;   // between edges: must take effect before the next rise
    #1;
    check("ar_async_forced", O_RESET);
    @(negedge Clk);
    #1;
    check("ar_held", O_RESET);
    Reset = 1'b1;
    #1;
    check("ar_release", O_RUN);
    @(negedge Clk);
    #1;
    check("ar_run_after", O_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline control block that drives the per-stage write-enable and synchronous-flush inputs of the pipelined datapath's stage registers.
- It detects load-use hazards and taken branches, and sequences multi-cycle EX operations (multiply) with an internal state machine and down-counter.
- It sits in ID alongside the decoder.
- Its outputs fan out to the Write and Reset pins of the PC, IF/ID, ID/EX and EX/MEM register banks.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width
- MUL_CYCLES, 4, total cycles a multi-cycle op occupies EX (legal range 1..15)
- CNT_W, 4, StallCount width (must hold MUL_CYCLES-1)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  reset; asynchronous and active-low
- ID_Rs  in  REG_ADDR_W  first source register of the instruction in ID
- ID_Rt  in  REG_ADDR_W  second source register of the instruction in ID
- ID_UsesRt  in  1  ID instruction reads Rt
- ID_MultiCycle  in  1  ID instruction is a multi-cycle EX op
- EX_MemRead  in  1  EX instruction is a load
- EX_Rd  in  REG_ADDR_W  destination register of the EX instruction
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle
- PC_Write  out  1  PC write enable
- IFID_Write  out  1  IF/ID write enable
- IDEX_Write  out  1  ID/EX write enable
- IFID_Flush  out  1  IF/ID synchronous clear
- IDEX_Flush  out  1  ID/EX synchronous clear (bubble insert)
- EXMEM_Flush  out  1  EX/MEM synchronous clear
- Busy  out  1  FSM in MC_BUSY
- StallCount  out  CNT_W  remaining MC_BUSY cycles

## Operation
- States: RUN, MC_BUSY. CNT_W-bit counter Count.
- Outputs are combinational from state, Count and inputs. Default is all *_Write=1 and all *_Flush=0.
- LoadUse = EX_MemRead & (EX_Rd != 0) & ((EX_Rd == ID_Rs) | (ID_UsesRt & (EX_Rd == ID_Rt))).
- RUN, priority from highest to lowest:
  - EX_BranchTaken: IFID_Flush=1, IDEX_Flush=1. Writes stay 1. No MC entry.
  - LoadUse: PC_Write=0, IFID_Write=0, IDEX_Flush=1. No MC entry. The condition clears naturally next cycle once the load advances.
  - ID_MultiCycle with MUL_CYCLES≥2: default outputs. At the edge the op enters EX, go to MC_BUSY and set Count←MUL_CYCLES-1.
  - If MUL_CYCLES=1, ID_MultiCycle is ignored.
- MC_BUSY:
  - Outputs: PC_Write=0, IFID_Write=0, IDEX_Write=0 (op held in EX), EXMEM_Flush=1 (bubbles downstream), IDEX_Flush=0, IFID_Flush=0.
  - EX_BranchTaken, LoadUse and ID_MultiCycle are ignored.
  - Each edge: Count←Count-1. When Count==1 at the edge, go to RUN with Count←0.
- Busy = (state==MC_BUSY). StallCount = Count (0 in RUN).
- Reset low, asynchronous: state←RUN, Count←0 immediately.
  - While low, outputs are forced to *_Write=0, *_Flush=1, Busy=0, StallCount=0, regardless of inputs.
  - Reset low mid-MC_BUSY aborts the op.

## Timing
- Hazard response is zero-latency: outputs change in the same cycle the inputs present the hazard.
- Load-use inserts exactly one bubble per hazard.
- Branch flush kills the two younger instructions in one cycle.
- A multi-cycle op occupies EX for MUL_CYCLES cycles: 1 issue cycle plus MUL_CYCLES-1 MC_BUSY cycles.
- The EX/MEM capture of the result happens on the first RUN cycle after MC_BUSY.
- Reset deassertion: first RUN outputs appear combinationally. The first state update is on the next rising edge.
- No output glitch constraints beyond a single combinational level after registered state.

## Test plan
- Reset: hold Reset=0 two cycles, inputs random -> PC/IFID/IDEX_Write=0, all Flush=1, Busy=0, StallCount=0. Release -> all Write=1, Flush=0.
- Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs=5 -> PC_Write=0, IFID_Write=0, IDEX_Flush=1 for one cycle. Repeat with EX_Rd=0 -> no stall. ID_Rt=5, ID_UsesRt=0 -> no stall.
- Priority: EX_BranchTaken=1 with LoadUse true and ID_MultiCycle=1 -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1, Busy stays 0 next cycle.
- Multi-cycle, MUL_CYCLES=4: ID_MultiCycle=1 in RUN -> next three cycles Busy=1, StallCount 3,2,1, EXMEM_Flush=1, IDEX_Write=0. Fourth cycle Busy=0, StallCount=0.
- Ignore during busy: in MC_BUSY assert EX_BranchTaken=1 and a load-use match -> IFID_Flush=0, IDEX_Flush=0, count sequence unchanged.
- Async reset mid-op: drop Reset between edges while StallCount=2 -> Busy=0 and StallCount=0 immediately, before the next edge. Release -> RUN.
